// File: rtl/sram_pkg.sv
// Shared defaults and FSM state encoding for the SRAM block fetcher.
package sram_pkg;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_DATA_W   = 128;
    localparam int unsigned DEF_STRIDE   = 16;
    localparam int unsigned DEF_READ_LAT = 2;

    // Latency counter covers READ_LAT up to 15; block count is a byte.
    localparam int unsigned LAT_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DRAIN,
        DONE
    } fetch_state_e;

endpackage

// File: rtl/blk_fifo2.sv
// Two-entry FIFO holding fetched blocks with their last flag; push and pop may coincide when full.
module blk_fifo2 #(
    parameter int unsigned W = 129
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sram_block_fetch.sv
// Fetches num_blocks strided blocks from a fixed-latency SRAM into a 2-deep output buffer,
// keeping at most one read outstanding and never reading without room for the data.
module sram_block_fetch
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned STRIDE   = DEF_STRIDE,
    parameter int unsigned READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_blocks,
    output logic              busy,
    output logic              done,
    output logic              sram_read,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [DATA_W-1:0] blk_data,
    output logic              blk_last
);

    fetch_state_e      state_q;
    logic [LAT_W-1:0]  lat_q;
    logic [CNT_W-1:0]  rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cap_q;
    logic              busy_q;
    logic              done_q;
    logic              read_q;

    logic              push_c;
    logic              pop_c;
    logic              slot_after_push_c;
    logic [1:0]        fifo_cnt;
    logic [DATA_W:0]   fifo_head;

    // cap_q marks that this CAPTURE already pushed and is now waiting for buffer room.
    assign push_c            = (state_q == CAPTURE) && !cap_q;
    assign pop_c             = blk_valid && blk_ready;
    assign slot_after_push_c = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            cap_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            read_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        addr_q <= base_addr;
                        rem_q  <= num_blocks;
                        lat_q  <= '0;
                        cap_q  <= 1'b0;
                        if (num_blocks == CNT_W'(0)) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= ISSUE;
                            read_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (lat_q == LAT_W'(READ_LAT - 1)) begin
                        read_q  <= 1'b0;
                        lat_q   <= '0;
                        cap_q   <= 1'b0;
                        state_q <= CAPTURE;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                CAPTURE: begin
                    if (!cap_q) begin
                        addr_q <= addr_q + ADDR_W'(STRIDE);
                        rem_q  <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= DRAIN;
                        end else if (slot_after_push_c) begin
                            state_q <= ISSUE;
                            read_q  <= 1'b1;
                        end else begin
                            cap_q <= 1'b1;
                        end
                    end else if (fifo_cnt != 2'd2) begin
                        cap_q   <= 1'b0;
                        state_q <= ISSUE;
                        read_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (fifo_cnt == 2'd0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    blk_fifo2 #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_c),
        .wdata_i({(rem_q == CNT_W'(1)), sram_rdata}),
        .pop_i  (pop_c),
        .rdata_o(fifo_head),
        .count_o(fifo_cnt)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign sram_read = read_q;
    assign sram_addr = addr_q;
    assign blk_valid = (fifo_cnt != 2'd0);
    assign blk_data  = fifo_head[DATA_W-1:0];
    assign blk_last  = blk_valid && fifo_head[DATA_W];

endmodule
